// File: rtl/alu_share_arbiter.sv
// Purpose : shares one integer ALU between the pipeline EX stage (port 0, priority) and the CNN scalar helper (port 1, tagged).
// Latency : grant and ALU operands are combinational in the request cycle; the response is registered and appears 1 cycle later.
// Backpr. : none on the response side; port 1 is force-granted after STARVE_LIMIT denied cycles, which stalls port 0 for one cycle.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   req0_* / req0_ready / flush0   pipeline request, grant, same-cycle response cancel
//   req1_* / req1_ready            accelerator request (with tag), grant
//   alu_ctl/alu_a/alu_b            operands to the shared ALU (zero when idle)
//   alu_result/alu_zero            combinational ALU outputs
//   rsp0_* / rsp1_*                registered responses; valid pulses for one cycle, data holds between pulses
module alu_share_arbiter #(
  parameter int WIDTH        = 32,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  input  logic [3:0]       req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             flush0,

  input  logic             req1_valid,
  input  logic [3:0]       req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,

  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,

  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [TAG_W-1:0] rsp1_tag
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic             starve;
  logic             grant0;
  logic             grant1;

  logic [CNT_W-1:0] wait_cnt_q,    wait_cnt_d;
  logic             rsp0_valid_q,  rsp0_valid_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic             rsp0_zero_q,   rsp0_zero_d;
  logic             rsp1_valid_q,  rsp1_valid_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic             rsp1_zero_q,   rsp1_zero_d;
  logic [TAG_W-1:0] rsp1_tag_q,    rsp1_tag_d;

  // Grant and ALU operand mux. A grant implies the port is valid, so
  // grantN is also the transfer strobe for that port.
  always_comb begin
    starve  = req1_valid && (wait_cnt_q == CNT_MAX);
    grant1  = starve || (req1_valid && !req0_valid);
    grant0  = req0_valid && !starve;
    alu_ctl = 4'b0000;
    alu_a   = '0;
    alu_b   = '0;
    if (grant1) begin
      alu_ctl = req1_ctl;
      alu_a   = req1_a;
      alu_b   = req1_b;
    end else if (grant0) begin
      alu_ctl = req0_ctl;
      alu_a   = req0_a;
      alu_b   = req0_b;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next-state: capture the ALU output for whichever port won. Result
  // data only moves on a transfer so it holds between valid pulses.
  always_comb begin
    rsp0_valid_d  = grant0 && !flush0;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_valid_d  = grant1;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;
    rsp1_tag_d    = rsp1_tag_q;
    wait_cnt_d    = wait_cnt_q;

    // A flushed transfer still overwrites the held data; only the pulse is suppressed.
    if (grant0) begin
      rsp0_result_d = alu_result;
      rsp0_zero_d   = alu_zero;
    end
    if (grant1) begin
      rsp1_result_d = alu_result;
      rsp1_zero_d   = alu_zero;
      rsp1_tag_d    = req1_tag;
    end

    // Counts consecutive cycles port 1 waited and lost; saturates so the
    // force-grant condition stays asserted until port 1 actually transfers.
    if (!req1_valid || grant1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
      rsp1_tag_q    <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
      rsp1_tag_q    <= rsp1_tag_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;
  assign rsp1_tag    = rsp1_tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : directed table-driven bench for alu_share_arbiter, plus starvation and reset sequences.
// Latency : checks grant/operands in the request cycle and responses one cycle later.
// Backpr. : none; all waits are fixed cycle counts.
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int NV    = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, flush0, req1_valid;
  logic [3:0]       req0_ctl, req1_ctl;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             req0_ready, req1_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero;
  logic             rsp0_valid, rsp0_zero, rsp1_valid, rsp1_zero;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic [TAG_W-1:0] rsp1_tag;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready), .flush0(flush0),
    .req1_valid(req1_valid), .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .req1_tag(req1_tag), .req1_ready(req1_ready),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .rsp1_tag(rsp1_tag)
  );

  // Simple ALU: and/or/add/sub/slt with a zero flag.
  always_comb begin
    case (alu_ctl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct packed {
    logic        v0;  logic [3:0] ctl0; logic [31:0] a0; logic [31:0] b0; logic fl0;
    logic        v1;  logic [3:0] ctl1; logic [31:0] a1; logic [31:0] b1; logic [3:0] tag1;
    logic        rdy0; logic rdy1; logic [3:0] actl; logic [31:0] aa; logic [31:0] ab;
    logic        r0v; logic [31:0] r0r; logic r0z;
    logic        r1v; logic [31:0] r1r; logic r1z; logic [3:0] r1t;
  } vec_t;

  vec_t vec [NV];

  task automatic vin(input int i, input logic v0, input logic [3:0] ctl0, input logic [31:0] a0,
                     input logic [31:0] b0, input logic fl0, input logic v1, input logic [3:0] ctl1,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] tag1);
    vec[i].v0 = v0; vec[i].ctl0 = ctl0; vec[i].a0 = a0; vec[i].b0 = b0; vec[i].fl0 = fl0;
    vec[i].v1 = v1; vec[i].ctl1 = ctl1; vec[i].a1 = a1; vec[i].b1 = b1; vec[i].tag1 = tag1;
  endtask

  task automatic vexp(input int i, input logic rdy0, input logic rdy1, input logic [3:0] actl,
                      input logic [31:0] aa, input logic [31:0] ab,
                      input logic r0v, input logic [31:0] r0r, input logic r0z,
                      input logic r1v, input logic [31:0] r1r, input logic r1z, input logic [3:0] r1t);
    vec[i].rdy0 = rdy0; vec[i].rdy1 = rdy1; vec[i].actl = actl; vec[i].aa = aa; vec[i].ab = ab;
    vec[i].r0v = r0v; vec[i].r0r = r0r; vec[i].r0z = r0z;
    vec[i].r1v = r1v; vec[i].r1r = r1r; vec[i].r1z = r1z; vec[i].r1t = r1t;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v0, input logic [3:0] ctl0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic fl0, input logic v1, input logic [3:0] ctl1,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] tag1);
    req0_valid = v0; req0_ctl = ctl0; req0_a = a0; req0_b = b0; flush0 = fl0;
    req1_valid = v1; req1_ctl = ctl1; req1_a = a1; req1_b = b1; req1_tag = tag1;
  endtask

  task automatic chk_rsp_zero(input string tagname);
    chk({tagname, " rsp0_valid"},  {31'd0, rsp0_valid}, 32'd0);
    chk({tagname, " rsp0_result"}, rsp0_result,          32'd0);
    chk({tagname, " rsp0_zero"},   {31'd0, rsp0_zero},  32'd0);
    chk({tagname, " rsp1_valid"},  {31'd0, rsp1_valid}, 32'd0);
    chk({tagname, " rsp1_result"}, rsp1_result,          32'd0);
    chk({tagname, " rsp1_zero"},   {31'd0, rsp1_zero},  32'd0);
    chk({tagname, " rsp1_tag"},    {28'd0, rsp1_tag},   32'd0);
    chk({tagname, " wait_cnt"},    {29'd0, dut.wait_cnt_q}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 4'd0);

    //          v0 ctl0     a0      b0    fl  v1 ctl1     a1            b1     tag
    vin(0,  1, 4'b0010, 5,     7,    0,  0, 4'b0000, 0,            0,     4'h0);
    vin(1,  0, 4'b0000, 0,     0,    0,  1, 4'b0110, 9,            9,     4'hA);
    vin(2,  0, 4'b0000, 0,     0,    0,  0, 4'b0000, 0,            0,     4'h0);
    vin(3,  1, 4'b0000, 'hF0,  'h0F, 0,  1, 4'b0001, 1,            2,     4'h3);
    vin(4,  0, 4'b0000, 0,     0,    0,  1, 4'b0001, 1,            2,     4'h3);
    vin(5,  1, 4'b0110, 4,     4,    1,  0, 4'b0000, 0,            0,     4'h0);
    vin(6,  1, 4'b0111, 3,     8,    0,  0, 4'b0000, 0,            0,     4'h0);
    vin(7,  0, 4'b0000, 0,     0,    1,  1, 4'b0010, 32'hFFFFFFFF, 1,     4'hF);
    vin(8,  0, 4'b0000, 0,     0,    0,  0, 4'b0000, 0,            0,     4'h0);
    //          rdy0 rdy1 actl     aa            ab    | r0v r0r r0z | r1v r1r r1z r1t
    vexp(0, 1, 0, 4'b0010, 5,            7,     1, 12, 0,  0, 0, 0, 4'h0);
    vexp(1, 0, 1, 4'b0110, 9,            9,     0, 12, 0,  1, 0, 1, 4'hA);
    vexp(2, 0, 0, 4'b0000, 0,            0,     0, 12, 0,  0, 0, 1, 4'hA);
    vexp(3, 1, 0, 4'b0000, 'hF0,         'h0F,  1, 0,  1,  0, 0, 1, 4'hA);
    vexp(4, 0, 1, 4'b0001, 1,            2,     0, 0,  1,  1, 3, 0, 4'h3);
    vexp(5, 1, 0, 4'b0110, 4,            4,     0, 0,  1,  0, 3, 0, 4'h3);
    vexp(6, 1, 0, 4'b0111, 3,            8,     1, 1,  0,  0, 3, 0, 4'h3);
    vexp(7, 0, 1, 4'b0010, 32'hFFFFFFFF, 1,     0, 1,  0,  1, 0, 1, 4'hF);
    vexp(8, 0, 0, 4'b0000, 0,            0,     0, 1,  0,  0, 0, 1, 4'hF);

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_rsp_zero("reset");
    reset = 1'b0;

    // Table: request-cycle checks for vector i, response checks for vector i-1.
    for (int i = 0; i <= NV; i++) begin
      @(posedge clk); #1;
      if (i < NV) drive(vec[i].v0, vec[i].ctl0, vec[i].a0, vec[i].b0, vec[i].fl0,
                        vec[i].v1, vec[i].ctl1, vec[i].a1, vec[i].b1, vec[i].tag1);
      else drive(0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 4'd0);
      @(negedge clk);
      if (i < NV) begin
        chk($sformatf("v%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vec[i].rdy0});
        chk($sformatf("v%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vec[i].rdy1});
        chk($sformatf("v%0d alu_ctl", i),    {28'd0, alu_ctl},    {28'd0, vec[i].actl});
        chk($sformatf("v%0d alu_a", i),      alu_a,               vec[i].aa);
        chk($sformatf("v%0d alu_b", i),      alu_b,               vec[i].ab);
      end
      if (i > 0) begin
        chk($sformatf("v%0d rsp0_valid", i-1),  {31'd0, rsp0_valid}, {31'd0, vec[i-1].r0v});
        chk($sformatf("v%0d rsp0_result", i-1), rsp0_result,         vec[i-1].r0r);
        chk($sformatf("v%0d rsp0_zero", i-1),   {31'd0, rsp0_zero},  {31'd0, vec[i-1].r0z});
        chk($sformatf("v%0d rsp1_valid", i-1),  {31'd0, rsp1_valid}, {31'd0, vec[i-1].r1v});
        chk($sformatf("v%0d rsp1_result", i-1), rsp1_result,         vec[i-1].r1r);
        chk($sformatf("v%0d rsp1_zero", i-1),   {31'd0, rsp1_zero},  {31'd0, vec[i-1].r1z});
        chk($sformatf("v%0d rsp1_tag", i-1),    {28'd0, rsp1_tag},   {28'd0, vec[i-1].r1t});
      end
    end

    // Starvation: both ports held valid; port 1 forced on cycles 4 and 9.
    do_reset();
    drive(1, 4'b0010, 1, 1, 0, 1, 4'b0010, 2, 2, 4'h5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("starve c%0d req0_ready", c), {31'd0, req0_ready}, (c == 4 || c == 9) ? 32'd0 : 32'd1);
      chk($sformatf("starve c%0d req1_ready", c), {31'd0, req1_ready}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
      if (c == 4) chk("starve c4 wait_cnt", {29'd0, dut.wait_cnt_q}, 32'd4);
      if (c == 5) begin
        chk("starve c5 wait_cnt",    {29'd0, dut.wait_cnt_q}, 32'd0);
        chk("starve c5 rsp1_valid",  {31'd0, rsp1_valid},     32'd1);
        chk("starve c5 rsp1_result", rsp1_result,             32'd4);
        chk("starve c5 rsp1_tag",    {28'd0, rsp1_tag},       32'd5);
        chk("starve c5 rsp0_valid",  {31'd0, rsp0_valid},     32'd0);
      end
      if (c >= 1 && c <= 4) chk($sformatf("starve c%0d rsp0_valid", c), {31'd0, rsp0_valid}, 32'd1);
      if (c == 3) chk("starve c3 rsp0_result", rsp0_result, 32'd2);
      @(posedge clk); #1;
    end

    // Reset in the cycle after a port-1 transfer: response is dropped.
    drive(0, 4'd0, 0, 0, 0, 1, 4'b0010, 3, 4, 4'h7);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 4'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_rsp_zero("in reset");
    chk("in reset req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_rsp_zero("after reset");
    chk("idle alu_ctl", {28'd0, alu_ctl}, 32'd0);
    chk("idle alu_a", alu_a, 32'd0);
    chk("idle req0_ready", {31'd0, req0_ready}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
